// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared types for the instruction-fetch stage:
//     word_t        32-bit machine word
//     ifetch_t      IF/ID latch contents {imemAddr, instr, pc}
//     pcsel_t       next-PC source select (00 seq, 01 branch, 10 jr, 11 jump)
//     fetch_state_t fetch FSM states (RUN, HALTED)
//   Also provides the sequential PC step, the bubble constant and a
//   word-alignment helper.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t imemAddr;  // address the instruction was fetched from
    word_t instr;     // instruction word
    word_t pc;        // fetch address + 4
  } ifetch_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsel_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t   PC_STEP     = 32'd4;
  // All-zero latch: instr 0 decodes as sll $0,$0,0 (nop).
  localparam ifetch_t IFID_BUBBLE = '0;

  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
//   Combinational redirect-target selection and word alignment.
//   Ports:
//     i_pc_sel     2   next-PC source select (pcsel_t encoding)
//     i_br_addr    32  branch target
//     i_jr_addr    32  jump-register target
//     i_j_addr     32  jump target
//     o_target     32  selected target, bits[1:0] forced to 00
//     o_redirect   1   pc_sel requests a redirect (non-sequential)
// ---------------------------------------------------------------------------
module pc_next_mux
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_br_addr,
  input  logic [31:0] i_jr_addr,
  input  logic [31:0] i_j_addr,
  output logic [31:0] o_target,
  output logic        o_redirect
);

  pcsel_t w_sel;
  word_t  w_raw;

  assign w_sel = pcsel_t'(i_pc_sel);

  always_comb begin
    w_raw = '0;
    unique case (w_sel)
      PC_BR:   w_raw = i_br_addr;
      PC_JR:   w_raw = i_jr_addr;
      PC_J:    w_raw = i_j_addr;
      default: w_raw = '0;
    endcase
  end

  assign o_target   = align_word(w_raw);
  assign o_redirect = (w_sel != PC_SEQ);

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, drives the instruction-memory read
//   request and loads the IF/ID latch. Redirects arriving while a fetch is
//   outstanding are buffered (pend) so the imem address never moves before
//   ihit.
//   Ports:
//     CLK, RST        clock / async active-high reset
//     ihit, iload     imem response (valid strobe, instruction word)
//     iREN, iaddr     imem request (combinational from state and PC)
//     stall, flush    hazard-unit controls
//     halt            decode saw HALT
//     pc_sel          00 seq, 01 branch, 10 jr, 11 jump
//     br_addr, jr_addr, j_addr   redirect targets
//     ifid, ifid_valid           IF/ID latch and its valid flag
//     dbg_state       current fetch FSM state
//     dbg_pend_valid  a buffered redirect is waiting for ihit
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ihit,
  input  logic [31:0]  iload,
  output logic         iREN,
  output logic [31:0]  iaddr,
  input  logic         stall,
  input  logic         flush,
  input  logic         halt,
  input  logic [1:0]   pc_sel,
  input  logic [31:0]  br_addr,
  input  logic [31:0]  jr_addr,
  input  logic [31:0]  j_addr,
  output ifetch_t      ifid,
  output logic         ifid_valid,
  output fetch_state_t dbg_state,
  output logic         dbg_pend_valid
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  word_t        r_pc;
  logic         r_pend_valid;
  word_t        r_pend_addr;
  ifetch_t      r_ifid;
  logic         r_ifid_valid;

  word_t        w_target;
  logic         w_redirect_req;
  logic         w_redirect_acc;
  logic         w_run;

  pc_next_mux u_pc_next_mux (
    .i_pc_sel   (pc_sel),
    .i_br_addr  (br_addr),
    .i_jr_addr  (jr_addr),
    .i_j_addr   (j_addr),
    .o_target   (w_target),
    .o_redirect (w_redirect_req)
  );

  assign w_run          = (r_state == RUN);
  assign w_redirect_acc = w_redirect_req && !stall && w_run;

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // FSM: next state and request outputs. HALTED is left only by reset.
  always_comb begin
    w_state_next = r_state;
    iREN         = 1'b0;
    unique case (r_state)
      RUN: begin
        iREN = 1'b1;
        if (halt) w_state_next = HALTED;
      end
      HALTED: begin
        iREN = 1'b0;
      end
      default: w_state_next = RUN;
    endcase
  end

  assign iaddr = r_pc;

  // PC / pending redirect. Stall freezes everything, including a hit in the
  // same cycle: the word is simply fetched again once the stall lifts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc         <= PC_INIT;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (w_run && !stall) begin
      if (w_redirect_acc) begin
        if (ihit) begin
          r_pc         <= w_target;
          r_pend_valid <= 1'b0;
        end else begin
          // Hold the request address until ihit; a newer redirect replaces
          // an older buffered one.
          r_pend_valid <= 1'b1;
          r_pend_addr  <= w_target;
        end
      end else if (ihit && r_pend_valid) begin
        r_pc         <= r_pend_addr;
        r_pend_valid <= 1'b0;
      end else if (ihit) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  // IF/ID latch. A word fetched in a redirect cycle (or while a redirect is
  // buffered) is from the wrong path and becomes a bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ifid       <= IFID_BUBBLE;
      r_ifid_valid <= 1'b0;
    end else if (flush || halt || !w_run) begin
      r_ifid       <= IFID_BUBBLE;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (w_redirect_acc || r_pend_valid || !ihit) begin
        r_ifid       <= IFID_BUBBLE;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid.imemAddr <= r_pc;
        r_ifid.instr    <= iload;
        r_ifid.pc       <= r_pc + PC_STEP;
        r_ifid_valid    <= 1'b1;
      end
    end
  end

  assign ifid           = r_ifid;
  assign ifid_valid     = r_ifid_valid;
  assign dbg_state      = r_state;
  assign dbg_pend_valid = r_pend_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Inputs change 1 time unit after the
//   rising edge; the expected IF/ID contents for each cycle are queued when
//   the cycle's stimulus is set and popped after the following edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int W = 97;  // {ifid_valid, ifid}

  logic         CLK;
  logic         RST;
  logic         ihit;
  logic [31:0]  iload;
  logic         iREN;
  logic [31:0]  iaddr;
  logic         stall;
  logic         flush;
  logic         halt;
  logic [1:0]   pc_sel;
  logic [31:0]  br_addr;
  logic [31:0]  jr_addr;
  logic [31:0]  j_addr;
  ifetch_t      ifid;
  logic         ifid_valid;
  fetch_state_t dbg_state;
  logic         dbg_pend_valid;

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_err;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .iload          (iload),
    .iREN           (iREN),
    .iaddr          (iaddr),
    .stall          (stall),
    .flush          (flush),
    .halt           (halt),
    .pc_sel         (pc_sel),
    .br_addr        (br_addr),
    .jr_addr        (jr_addr),
    .j_addr         (j_addr),
    .ifid           (ifid),
    .ifid_valid     (ifid_valid),
    .dbg_state      (dbg_state),
    .dbg_pend_valid (dbg_pend_valid)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // generic 32-bit comparison
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: queue the expected latch, advance, pop and compare
  task automatic cyc(input string tag, input logic v, input logic [31:0] a,
                     input logic [31:0] ins, input logic [31:0] p);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    exp_q.push_back({v, a, ins, p});
    @(posedge CLK);
    #1;
    got = {ifid_valid, ifid};
    exp = exp_q.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bub(input string tag);
    cyc(tag, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  localparam logic [31:0] I0 = 32'h2001_0005;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    RST     = 1'b1;
    ihit    = 1'b0;
    iload   = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    halt    = 1'b0;
    pc_sel  = 2'b00;
    br_addr = '0;
    jr_addr = '0;
    j_addr  = '0;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h1);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_ifid_instr", ifid.instr, 32'h0);
    chk("rst_state", {31'b0, dbg_state}, {31'b0, RUN});
    chk("rst_pend", {31'b0, dbg_pend_valid}, 32'h0);
    RST = 1'b0;

    // zero-wait sequential fetch
    ihit  = 1'b1;
    iload = I0;
    for (int k = 0; k < 4; k++) begin
      cyc("seq_ifid", 1'b1, 32'(4 * k), I0, 32'(4 * k + 4));
      chk("seq_iaddr", iaddr, 32'(4 * k + 4));
    end

    // three-cycle miss at 0x10
    ihit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bub("miss_ifid");
      chk("miss_iaddr", iaddr, 32'h10);
      chk("miss_iren", {31'b0, iREN}, 32'h1);
    end
    ihit  = 1'b1;
    iload = 32'hAAAA_0001;
    cyc("miss_hit_ifid", 1'b1, 32'h10, 32'hAAAA_0001, 32'h14);
    chk("miss_hit_iaddr", iaddr, 32'h14);
    iload = 32'h0000_0001;
    for (int k = 0; k < 3; k++)
      cyc("seq2_ifid", 1'b1, 32'(32'h14 + 4 * k), 32'h1, 32'(32'h18 + 4 * k));
    chk("seq2_iaddr", iaddr, 32'h20);

    // jump during a miss is buffered until ihit
    ihit   = 1'b0;
    pc_sel = 2'b11;
    j_addr = 32'h40;
    bub("pend_set_ifid");
    chk("pend_set_iaddr", iaddr, 32'h20);
    chk("pend_set_flag", {31'b0, dbg_pend_valid}, 32'h1);
    pc_sel = 2'b00;
    bub("pend_wait_ifid");
    chk("pend_wait_iaddr", iaddr, 32'h20);
    ihit = 1'b1;
    bub("pend_hit_ifid");
    chk("pend_hit_iaddr", iaddr, 32'h40);
    chk("pend_hit_flag", {31'b0, dbg_pend_valid}, 32'h0);

    // a newer buffered redirect overwrites the older one (jr, aligned)
    ihit   = 1'b0;
    pc_sel = 2'b11;
    j_addr = 32'h80;
    bub("ovw1_ifid");
    pc_sel  = 2'b10;
    jr_addr = 32'h63;
    bub("ovw2_ifid");
    chk("ovw_iaddr", iaddr, 32'h40);
    pc_sel = 2'b00;
    ihit   = 1'b1;
    bub("ovw_hit_ifid");
    chk("ovw_hit_iaddr", iaddr, 32'h60);

    // branch with hit: one bubble, aligned target
    pc_sel  = 2'b01;
    br_addr = 32'h103;
    bub("br_ifid");
    chk("br_iaddr", iaddr, 32'h100);
    pc_sel = 2'b00;
    iload  = 32'h8C22_0000;
    cyc("br_next_ifid", 1'b1, 32'h100, 32'h8C22_0000, 32'h104);
    chk("br_next_iaddr", iaddr, 32'h104);

    // set up a valid latch with PC=0x8
    pc_sel = 2'b11;
    j_addr = 32'h4;
    bub("j4_ifid");
    chk("j4_iaddr", iaddr, 32'h4);
    pc_sel = 2'b00;
    iload  = 32'h1111_2222;
    cyc("pre_stall_ifid", 1'b1, 32'h4, 32'h1111_2222, 32'h8);

    // stall with hit holds PC and latch; redirect under stall not accepted
    stall = 1'b1;
    iload = 32'hDEAD_BEEF;
    cyc("stall1_ifid", 1'b1, 32'h4, 32'h1111_2222, 32'h8);
    chk("stall1_iaddr", iaddr, 32'h8);
    pc_sel  = 2'b01;
    br_addr = 32'h200;
    cyc("stall2_ifid", 1'b1, 32'h4, 32'h1111_2222, 32'h8);
    chk("stall2_iaddr", iaddr, 32'h8);
    chk("stall2_pend", {31'b0, dbg_pend_valid}, 32'h0);
    pc_sel = 2'b00;
    flush  = 1'b1;
    bub("flush_stall_ifid");
    chk("flush_stall_iaddr", iaddr, 32'h8);
    stall = 1'b0;
    flush = 1'b0;
    iload = 32'h3333_4444;
    cyc("post_stall_ifid", 1'b1, 32'h8, 32'h3333_4444, 32'hC);
    chk("post_stall_iaddr", iaddr, 32'hC);
    flush = 1'b1;
    bub("flush_ifid");
    chk("flush_iaddr", iaddr, 32'h10);
    flush = 1'b0;

    // halt at 0x30
    pc_sel = 2'b11;
    j_addr = 32'h30;
    bub("j30_ifid");
    chk("j30_iaddr", iaddr, 32'h30);
    pc_sel = 2'b00;
    ihit   = 1'b0;
    halt   = 1'b1;
    bub("halt_ifid");
    chk("halt_iren", {31'b0, iREN}, 32'h0);
    chk("halt_iaddr", iaddr, 32'h30);
    chk("halt_state", {31'b0, dbg_state}, {31'b0, HALTED});
    halt   = 1'b0;
    ihit   = 1'b1;
    pc_sel = 2'b11;
    j_addr = 32'h90;
    iload  = 32'h5555_5555;
    for (int k = 0; k < 2; k++) begin
      bub("halted_ifid");
      chk("halted_iaddr", iaddr, 32'h30);
      chk("halted_iren", {31'b0, iREN}, 32'h0);
    end

    // asynchronous reset out of HALTED
    RST = 1'b1;
    #1;
    chk("arst_iaddr", iaddr, 32'h0);
    chk("arst_iren", {31'b0, iREN}, 32'h1);
    chk("arst_state", {31'b0, dbg_state}, {31'b0, RUN});
    @(negedge CLK);
    RST    = 1'b0;
    pc_sel = 2'b00;
    iload  = 32'h0000_0055;
    cyc("after_rst_ifid", 1'b1, 32'h0, 32'h55, 32'h4);
    chk("after_rst_iaddr", iaddr, 32'h4);

    // reset mid-run clears a buffered redirect and the latch
    ihit   = 1'b0;
    pc_sel = 2'b11;
    j_addr = 32'h50;
    bub("pend2_ifid");
    chk("pend2_flag", {31'b0, dbg_pend_valid}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst2_pend", {31'b0, dbg_pend_valid}, 32'h0);
    chk("arst2_iaddr", iaddr, 32'h0);
    chk("arst2_valid", {31'b0, ifid_valid}, 32'h0);
    @(negedge CLK);
    RST    = 1'b0;

    // PC wrap from 0xFFFF_FFFC
    pc_sel = 2'b11;
    j_addr = 32'hFFFF_FFFF;
    ihit   = 1'b1;
    bub("jtop_ifid");
    chk("jtop_iaddr", iaddr, 32'hFFFF_FFFC);
    pc_sel = 2'b00;
    iload  = 32'h0000_0077;
    cyc("wrap_ifid", 1'b1, 32'hFFFF_FFFC, 32'h77, 32'h0);
    chk("wrap_iaddr", iaddr, 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
